dot_matrix_scan_scheduler: RTL

//  Time-multiplexes one shared synchronous ASCII glyph ROM across NUM_DISP 8x8 dot-matrix displays (e.g. P1/P2 scores).
//  Per row period: fetches each display's glyph row in turn, buffers the rows in shadow registers, then commits all columns and the row strobe together.

---
 rtl/dot_matrix_scan_scheduler_if.sv | 26 ++
 rtl/dot_matrix_scan_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dot_matrix_scan_scheduler_if.sv
// Scheduler bus: ASCII codes and enable in, shared glyph-ROM port, matrix row/col drive out.
// BLINK_DISP_EN adds the per-display blink request.
interface dot_matrix_scan_scheduler_if #(
    parameter int NUM_DISP = 2
);
    logic                      enable;
    logic [7*NUM_DISP-1:0]     codes;
    logic [9:0]                rom_addr;
    logic [7:0]                rom_data;
    logic [7:0]                row;
    logic [8*NUM_DISP-1:0]     col;
    logic                      frame_start;
`ifdef BLINK_DISP_EN
    logic [NUM_DISP-1:0]       blink;

    modport master (output enable, codes, rom_data, blink,
                    input  rom_addr, row, col, frame_start);
    modport slave  (input  enable, codes, rom_data, blink,
                    output rom_addr, row, col, frame_start);
`else
    modport master (output enable, codes, rom_data,
                    input  rom_addr, row, col, frame_start);
    modport slave  (input  enable, codes, rom_data,
                    output rom_addr, row, col, frame_start);
`endif
endinterface

// File: rtl/dot_matrix_scan_scheduler.sv
// Shares one synchronous glyph ROM across NUM_DISP 8x8 matrices, one row per ROW_DIV cycles.
// Optional feature macro: BLINK_DISP_EN (per-display blanking every BLINK_FRAMES frames).
module dot_matrix_scan_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap,
    input  logic [7:0] d,
    output logic [7:0] q
);
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (cap) q <= d;
    end
endmodule

module dot_matrix_scan_scheduler #(
    parameter int NUM_DISP    = 2,
    parameter int ROW_DIV     = 1000,
    parameter int CODE_OFFSET = 48
`ifdef BLINK_DISP_EN
    , parameter int BLINK_FRAMES = 32
`endif
) (
    input logic clk,
    input logic rst,
    dot_matrix_scan_scheduler_if.slave bus
);
    localparam int CW = $clog2(ROW_DIV);
    localparam int IW = (NUM_DISP > 1) ? $clog2(NUM_DISP) : 1;

    typedef enum logic [1:0] {WAIT, FETCH, DRAIN} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              cnt;
    logic [2:0]                 fr;
    logic [NUM_DISP-1:0][6:0]   code_snap;
    logic [NUM_DISP-1:0][7:0]   shadow;
    logic [NUM_DISP-1:0][7:0]   commit_col;
    logic [9:0]                 addr_q;
    logic [9:0]                 addr_nxt;
    logic [6:0]                 code_lk;
    logic                       issue;
    logic [IW-1:0]              issue_idx;
    logic                       cap_vld;
    logic [IW-1:0]              cap_idx;
    logic                       tick;

    assign tick = (cnt == CW'(ROW_DIV - 1));

    // Display 0 is issued from WAIT itself so its address lands on cnt==0.
    // rst/enable gate issue combinationally so rom_addr freezes immediately.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        issue_idx = '0;
        case (state)
            WAIT: begin
                if (cnt == '0) begin
                    issue     = 1'b1;
                    state_nxt = (NUM_DISP == 1) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                issue     = 1'b1;
                issue_idx = cnt[IW-1:0];
                if (cnt == CW'(NUM_DISP - 1)) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = WAIT;
            default: state_nxt = WAIT;
        endcase
        if (rst || !bus.enable) begin
            issue     = 1'b0;
            state_nxt = WAIT;
        end
    end

    always_comb begin
        code_lk  = code_snap[issue_idx] + 7'(CODE_OFFSET);
        addr_nxt = {code_lk, fr};
    end

    assign bus.rom_addr = issue ? addr_nxt : addr_q;

    generate
        for (genvar i = 0; i < NUM_DISP; i++) begin : g_lane
            dot_matrix_scan_lane u_lane (
                .clk (clk),
                .rst (rst),
                .cap (cap_vld && bus.enable && (cap_idx == IW'(i))),
                .d   (bus.rom_data),
                .q   (shadow[i])
            );
        end
    endgenerate

`ifdef BLINK_DISP_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (bus.frame_start) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_DISP; i++)
            commit_col[i] = (blink_phase && bus.blink[i]) ? 8'h00 : shadow[i];
    end
`else
    assign commit_col = shadow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= WAIT;
            cnt             <= '0;
            fr              <= '0;
            code_snap       <= '0;
            addr_q          <= '0;
            cap_vld         <= 1'b0;
            cap_idx         <= '0;
            bus.row         <= '0;
            bus.col         <= '0;
            bus.frame_start <= 1'b0;
        end else if (!bus.enable) begin
            // Blank and park at frame start; in-flight ROM words are dropped.
            state           <= WAIT;
            cnt             <= '0;
            fr              <= '0;
            code_snap       <= bus.codes;
            addr_q          <= bus.rom_addr;
            cap_vld         <= 1'b0;
            bus.row         <= '0;
            bus.col         <= '0;
            bus.frame_start <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= tick ? '0 : cnt + 1'b1;
            addr_q          <= bus.rom_addr;
            cap_vld         <= issue;
            cap_idx         <= issue_idx;
            bus.frame_start <= tick && (fr == 3'd0);
            if (tick) begin
                bus.row <= 8'd1 << fr;
                bus.col <= commit_col;
                fr      <= fr + 3'd1;
                // Codes only change between frames, never mid-glyph.
                if (fr == 3'd7) code_snap <= bus.codes;
            end
        end
    end
endmodule
